// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with branch/jump/call/return redirection and a
// circular return-address stack that reports empty/full and sticky ovf/unf status.
module pc_ras_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                STEP       = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}},
    parameter int                JUMP_W     = 26,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch,
    input  logic              alu_zero,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic [ADDR_W-1:0] pc_plus_in,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [JUMP_W-1:0] jump_field,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic [ADDR_W-1:0] br_target,
    output logic              redirect,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] stack_r [RAS_DEPTH];
    logic [PTR_W-1:0]  sp_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ovf_r;
    logic              unf_r;

    logic              taken_s;
    logic              pop_s;
    logic              push_s;
    logic              jump_s;
    logic              under_s;
    logic [ADDR_W-1:0] top_s;
    logic [ADDR_W-1:0] jmp_tgt_s;
    logic [ADDR_W-1:0] next_pc_s;

    // A taken branch squashes the younger jump/call/ret; ret outranks call.
    assign taken_s   = branch & alu_zero;
    assign pop_s     = ~taken_s & ret & ~ras_empty;
    assign under_s   = ~taken_s & ret & ras_empty;
    assign push_s    = ~taken_s & ~ret & call;
    assign jump_s    = ~taken_s & (jump | push_s);

    // sp_r addresses the next free slot, so the top lives one below it.
    assign top_s     = stack_r[sp_r - PTR_W'(1)];
    assign jmp_tgt_s = {pc_plus_in[ADDR_W-1:JUMP_W], jump_field};

    assign pc        = pc_r;
    assign pc_plus   = pc_r + ADDR_W'(STEP);
    assign br_target = pc_plus_in + br_offset;
    assign redirect  = taken_s | pop_s | jump_s;
    assign ras_empty = (cnt_r == {CNT_W{1'b0}});
    assign ras_full  = (cnt_r == FULL_CNT);
    assign ras_ovf   = ovf_r;
    assign ras_unf   = unf_r;

    // Next-PC selection in priority order.
    always_comb begin
        next_pc_s = pc_plus;
        if (taken_s) begin
            next_pc_s = br_target;
        end else if (pop_s) begin
            next_pc_s = top_s;
        end else if (jump_s) begin
            next_pc_s = jmp_tgt_s;
        end else if (stall) begin
            next_pc_s = pc_r;
        end else begin
            next_pc_s = pc_plus;
        end
    end

    // PC register, stack storage, occupancy and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r  <= RESET_ADDR;
            sp_r  <= {PTR_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            pc_r <= next_pc_s;
            if (push_s) begin
                // On a full stack this slot holds the oldest entry.
                stack_r[sp_r] <= pc_plus_in;
                sp_r          <= sp_r + PTR_W'(1);
                if (ras_full) begin
                    ovf_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else if (pop_s) begin
                sp_r  <= sp_r - PTR_W'(1);
                cnt_r <= cnt_r - CNT_W'(1);
            end
            if (under_s) begin
                unf_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit: expected PCs are queued when stimulus is
// applied and compared after the clock edge that should produce them.
module tb_pc_ras_unit;
    logic        clk = 1'b0;
    logic        reset, stall, branch, alu_zero, jump, call, ret;
    logic [31:0] br_offset, pc_plus_in;
    logic [25:0] jump_field;
    logic [31:0] pc, pc_plus, br_target;
    logic        redirect, ras_empty, ras_full, ras_ovf, ras_unf;

    logic [31:0] exp_q [$];
    logic [31:0] model_stack [$];
    logic [31:0] e;
    int          errors = 0;
    int          checks = 0;

    pc_ras_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .alu_zero(alu_zero), .br_offset(br_offset), .pc_plus_in(pc_plus_in),
        .jump(jump), .call(call), .ret(ret), .jump_field(jump_field),
        .pc(pc), .pc_plus(pc_plus), .br_target(br_target), .redirect(redirect),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; branch = 1'b0; alu_zero = 1'b0;
        jump = 1'b0; call = 1'b0; ret = 1'b0;
        br_offset = 32'h0; pc_plus_in = 32'h0; jump_field = 26'h0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags got=%b exp=1000", {ras_empty, ras_full, ras_ovf, ras_unf});
        end
    endtask

    task automatic test_sequential();
        idle();
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(32'(i));
            tick();
            e = exp_q.pop_front();
            checks++; if (pc !== e) begin errors++; $display("FAIL seq_pc got=%h exp=%h", pc, e); end
        end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL stall_redirect got=%b exp=0", redirect); end
            exp_q.push_back(32'h3);
            tick();
            e = exp_q.pop_front();
            checks++; if (pc !== e) begin errors++; $display("FAIL stall_pc got=%h exp=%h", pc, e); end
        end
    endtask

    task automatic test_branch();
        idle();
        stall = 1'b1; branch = 1'b1; alu_zero = 1'b1;
        pc_plus_in = 32'h10; br_offset = 32'hFFFF_FFFC;
        #1;
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL br_redirect got=%b exp=1", redirect); end
        checks++; if (br_target !== 32'hC) begin errors++; $display("FAIL br_target got=%h exp=%h", br_target, 32'hC); end
        exp_q.push_back(32'hC);
        tick();
        e = exp_q.pop_front();
        checks++; if (pc !== e) begin errors++; $display("FAIL br_pc got=%h exp=%h", pc, e); end
        alu_zero = 1'b0;
        #1;
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL nt_redirect got=%b exp=0", redirect); end
        exp_q.push_back(32'hC);
        tick();
        e = exp_q.pop_front();
        checks++; if (pc !== e) begin errors++; $display("FAIL nt_pc got=%h exp=%h", pc, e); end
    endtask

    task automatic test_jump();
        idle();
        jump = 1'b1; pc_plus_in = 32'hF000_0010; jump_field = 26'h3;
        #1;
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL jmp_redirect got=%b exp=1", redirect); end
        exp_q.push_back(32'hF000_0003);
        tick();
        e = exp_q.pop_front();
        checks++; if (pc !== e) begin errors++; $display("FAIL jmp_pc got=%h exp=%h", pc, e); end
        // taken branch together with jump and call: branch wins, nothing pushed
        call = 1'b1; branch = 1'b1; alu_zero = 1'b1;
        pc_plus_in = 32'h10; br_offset = 32'h10;
        exp_q.push_back(32'h20);
        tick();
        e = exp_q.pop_front();
        checks++; if (pc !== e) begin errors++; $display("FAIL br_over_jmp_pc got=%h exp=%h", pc, e); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL br_over_call_push got=%b exp=1", ras_empty); end
    endtask

    task automatic test_ras();
        logic [31:0] vals [5];
        logic [31:0] tgt;
        vals = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        idle();
        for (int i = 0; i < 5; i++) begin
            call = 1'b1; pc_plus_in = vals[i]; jump_field = 26'(32'h100 + i);
            tgt = {pc_plus_in[31:26], jump_field};
            exp_q.push_back(tgt);
            model_stack.push_back(vals[i]);
            if (model_stack.size() > 4) void'(model_stack.pop_front());
            tick();
            e = exp_q.pop_front();
            checks++; if (pc !== e) begin errors++; $display("FAIL call_pc[%0d] got=%h exp=%h", i, pc, e); end
            checks++; if (ras_full !== (i >= 3)) begin errors++; $display("FAIL call_full[%0d] got=%b exp=%b", i, ras_full, (i >= 3)); end
            checks++; if (ras_ovf !== (i == 4)) begin errors++; $display("FAIL call_ovf[%0d] got=%b exp=%b", i, ras_ovf, (i == 4)); end
        end
        idle();
        ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL ret_redirect[%0d] got=%b exp=1", i, redirect); end
            exp_q.push_back(model_stack.pop_back());
            tick();
            e = exp_q.pop_front();
            checks++; if (pc !== e) begin errors++; $display("FAIL ret_pc[%0d] got=%h exp=%h", i, pc, e); end
        end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got=%b exp=1", ras_empty); end
        #1;
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL unf_redirect got=%b exp=0", redirect); end
        exp_q.push_back(32'h22 + 32'h1);
        tick();
        e = exp_q.pop_front();
        checks++; if (pc !== e) begin errors++; $display("FAIL unf_pc got=%h exp=%h", pc, e); end
        checks++; if ({ras_unf, ras_ovf, ras_empty} !== 3'b111) begin
            errors++; $display("FAIL unf_flags got=%b exp=111", {ras_unf, ras_ovf, ras_empty});
        end
    endtask

    task automatic test_wrap();
        idle();
        jump = 1'b1; pc_plus_in = 32'hFC00_0000; jump_field = 26'h3FF_FFFF;
        exp_q.push_back(32'hFFFF_FFFF);
        tick();
        e = exp_q.pop_front();
        checks++; if (pc !== e) begin errors++; $display("FAIL wrap_load got=%h exp=%h", pc, e); end
        idle();
        pc_plus_in = 32'hFFFF_FFFF; br_offset = 32'h2;
        #1;
        checks++; if (pc_plus !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus got=%h exp=%h", pc_plus, 32'h0); end
        checks++; if (br_target !== 32'h1) begin errors++; $display("FAIL wrap_br_target got=%h exp=%h", br_target, 32'h1); end
        exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front();
        checks++; if (pc !== e) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc, e); end
    endtask

    task automatic test_back_to_back();
        idle();
        call = 1'b1; pc_plus_in = 32'hAA;
        tick();
        call = 1'b0; ret = 1'b1;
        exp_q.push_back(32'hAA);
        tick();
        e = exp_q.pop_front();
        checks++; if (pc !== e) begin errors++; $display("FAIL b2b_ret_pc got=%h exp=%h", pc, e); end
    endtask

    task automatic test_reset_mid();
        idle();
        call = 1'b1; pc_plus_in = 32'h77; jump_field = 26'h40;
        tick();
        checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL mid_pre_empty got=%b exp=0", ras_empty); end
        pc_plus_in = 32'h88; reset = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        idle();
        e = exp_q.pop_front();
        checks++; if (pc !== e) begin errors++; $display("FAIL mid_reset_pc got=%h exp=%h", pc, e); end
        checks++; if ({ras_empty, ras_ovf, ras_unf} !== 3'b100) begin
            errors++; $display("FAIL mid_reset_flags got=%b exp=100", {ras_empty, ras_ovf, ras_unf});
        end
        exp_q.push_back(32'h1);
        tick();
        e = exp_q.pop_front();
        checks++; if (pc !== e) begin errors++; $display("FAIL mid_release_pc got=%h exp=%h", pc, e); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_ras();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
